// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Instruction-memory fetch bus between the CPU1 control
//                sequencer (master) and instruction memory (slave).
//                  imem_req   master->slave  fetch request
//                  imem_addr  master->slave  fetch address (PC_W bits)
//                  imem_ack   slave->master  imem_rdata valid this cycle
//                  imem_rdata slave->master  16-bit instruction word
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle control sequencer for the CPU1 datapath.
//                Fetches 16-bit instructions over a req/ack bus, holds them
//                in the instruction register and steps the datapath through
//                DECODE / EXEC / WB with one-cycle enable strobes. Owns the
//                program counter, JMP / HALT control flow and a retired-
//                instruction counter.
//  Ports       : clk      system clock, rising edge
//                res      asynchronous active-low reset
//                start    leave IDLE / HALT and begin fetching
//                imem     fetch bus (master modport)
//                inst     instruction register
//                dec_en   decoder latch strobe
//                exe_en   ALU / bus operation strobe
//                wb_en    register-file write-back strobe
//                pc       program counter
//                halted   high while in HALT
//                busy     high outside IDLE and HALT
//                instret  retired-instruction count (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            start,
  cpu_sequencer_if.master imem,
  output logic [15:0]     inst,
  output logic            dec_en,
  output logic            exe_en,
  output logic            wb_en,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            busy,
  output logic [15:0]     instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0]      OP_JMP  = 4'b0111;
  localparam logic [3:0]      OP_HALT = 4'b1111;
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [15:0]     RET_ONE = 16'd1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     inst_q, inst_d;
  logic [15:0]     instret_q, instret_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic            dec_en_q, dec_en_d;
  logic            exe_en_q, exe_en_d;
  logic            wb_en_q, wb_en_d;
  logic            halted_q, halted_d;
  logic            busy_q, busy_d;
  logic [PC_W-1:0] jmp_target;
  logic            active_d;

  // Jump target is the 9-bit immediate, zero-extended or truncated to PC_W.
  generate
    if (PC_W > 9) begin : g_jmp_zext
      assign jmp_target = {{(PC_W-9){1'b0}}, inst_q[8:0]};
    end else begin : g_jmp_trunc
      assign jmp_target = inst_q[PC_W-1:0];
    end
  endgenerate

  // ALU ops (ADD..XOR) and LOADI are the only opcodes that touch the
  // datapath; NOP and every unassigned opcode run through EXEC/WB silently.
  function automatic logic op_is_active(input logic [3:0] op);
    return (op >= 4'b0001) && (op <= 4'b0110);
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          inst_d  = imem.imem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (inst_q[15:12] == OP_HALT) begin
          instret_d = instret_q + RET_ONE;
          state_d   = S_HALT;
        end else if (inst_q[15:12] == OP_JMP) begin
          pc_d      = jmp_target;
          instret_d = instret_q + RET_ONE;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        instret_d = instret_q + RET_ONE;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        // Resumes at the address following the HALT word.
        if (start) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of a decode of the next state, so each
    // one is a pure function of the registered state (Moore behaviour).
    active_d    = op_is_active(inst_d[15:12]);
    imem_req_d  = (state_d == S_FETCH);
    imem_addr_d = (state_d == S_FETCH) ? pc_d : '0;
    dec_en_d    = (state_d == S_DECODE);
    exe_en_d    = (state_d == S_EXEC) && active_d;
    wb_en_d     = (state_d == S_WB) && active_d;
    halted_d    = (state_d == S_HALT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      instret_q   <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      dec_en_q    <= 1'b0;
      exe_en_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instret_q   <= instret_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      dec_en_q    <= dec_en_d;
      exe_en_q    <= exe_en_d;
      wb_en_q     <= wb_en_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign inst           = inst_q;
  assign dec_en         = dec_en_q;
  assign exe_en         = exe_en_q;
  assign wb_en          = wb_en_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign busy           = busy_q;
  assign instret        = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. An instruction-memory
//                model answers fetches with a programmable number of wait
//                cycles; a scoreboard holds the expected fetch address and
//                instruction word of every fetch, checked when the DUT
//                accepts the fetch and when it strobes dec_en.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int PC_W = 8;

  logic            clk;
  logic            res;
  logic            start;
  logic [15:0]     inst;
  logic            dec_en;
  logic            exe_en;
  logic            wb_en;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            busy;
  logic [15:0]     instret;

  cpu_sequencer_if #(.PC_W(PC_W)) imem_if ();

  cpu_sequencer #(.PC_W(PC_W)) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .imem    (imem_if),
    .inst    (inst),
    .dec_en  (dec_en),
    .exe_en  (exe_en),
    .wb_en   (wb_en),
    .pc      (pc),
    .halted  (halted),
    .busy    (busy),
    .instret (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int wait_cfg = 0;

  logic [15:0] mem [0:255];

  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [15:0]     word;
  } fetch_t;

  fetch_t exp_q[$];
  bit     pending = 1'b0;

  // Per-cycle {imem_req, dec_en, exe_en, wb_en} and pc for ADD, LOADI, NOP.
  logic [3:0]      strb_tbl [12] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                     4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                     4'b1000, 4'b0100, 4'b0000, 4'b0000};
  logic [PC_W-1:0] pc_tbl   [12] = '{8'd0, 8'd1, 8'd1, 8'd1,
                                     8'd1, 8'd2, 8'd2, 8'd2,
                                     8'd2, 8'd3, 8'd3, 8'd3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({imem_if.imem_req, imem_if.imem_addr, dec_en, exe_en, wb_en, halted, busy});
  endfunction

  // Instruction memory with wait_cfg ack-low cycles before each ack.
  initial begin : mem_model
    int wcnt;
    wcnt = 0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!res || !imem_if.imem_req) begin
        wcnt = 0;
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 16'hDEAD;
      end else if (wcnt >= wait_cfg) begin
        wcnt = 0;
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = mem[imem_if.imem_addr];
      end else begin
        wcnt++;
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 16'hDEAD;
      end
    end
  end

  // Scoreboard: address checked on fetch acceptance, word checked on dec_en.
  initial begin : sb_monitor
    forever begin
      @(negedge clk);
      #1;
      if (res && dec_en && pending) begin
        check("sb_inst", 32'(inst), 32'(exp_q[0].word));
        void'(exp_q.pop_front());
        pending = 1'b0;
      end
      if (res && imem_if.imem_req && imem_if.imem_ack) begin
        check("sb_fetch_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          check("sb_fetch_addr", 32'(imem_if.imem_addr), 32'(exp_q[0].addr));
          pending = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    res   = 1'b0;
    start = 1'b0;
    foreach (mem[a]) mem[a] = 16'h0000;
    mem[0]   = 16'h1250;  // ADD
    mem[1]   = 16'h6A05;  // LOADI
    mem[2]   = 16'h0000;  // NOP
    mem[3]   = 16'h0000;  // NOP
    mem[4]   = 16'hF000;  // HALT
    mem[5]   = 16'h70FF;  // JMP 0xFF
    mem[255] = 16'h1250;  // ADD

    // Reset and idle
    tick(3);
    check("rst_outputs", out_vec(), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_inst", 32'(inst), 0);
    check("rst_instret", 32'(instret), 0);
    res = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("idle_outputs_%0d", i), out_vec() | 32'(pc), 0);
    end

    // Straight-line ADD, LOADI, NOP with zero-wait memory, then NOP, HALT
    for (int a = 0; a < 5; a++) exp_q.push_back('{addr: PC_W'(a), word: mem[a]});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("line_strobes_%0d", i),
            32'({imem_if.imem_req, dec_en, exe_en, wb_en}), 32'(strb_tbl[i]));
      check($sformatf("line_pc_%0d", i), 32'(pc), 32'(pc_tbl[i]));
      tick(1);
    end
    check("line_instret", 32'(instret), 3);
    check("line_pc_end", 32'(pc), 3);

    // HALT at address 4
    tick(5);
    check("halt_decode", 32'({dec_en, inst}), 32'({1'b1, 16'hF000}));
    check("halt_instret_before", 32'(instret), 4);
    tick(1);
    check("halt_flags", 32'({halted, busy}), 32'(2'b10));
    check("halt_pc", 32'(pc), 5);
    check("halt_instret", 32'(instret), 5);
    tick(3);
    check("halt_hold", 32'({halted, busy, imem_if.imem_req}), 32'(3'b100));
    check("halt_instret_hold", 32'(instret), 5);

    // Resume at 5: JMP 0xFF, ADD at 0xFF, pc wraps to 0
    exp_q.push_back('{addr: 8'h05, word: 16'h70FF});
    exp_q.push_back('{addr: 8'hFF, word: 16'h1250});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("resume_fetch", 32'({imem_if.imem_req, imem_if.imem_addr}), 32'({1'b1, 8'h05}));
    tick(1);
    check("jmp_decode", 32'({dec_en, inst}), 32'({1'b1, 16'h70FF}));
    check("jmp_pc_inc", 32'(pc), 6);
    tick(1);
    check("jmp_fetch", 32'({imem_if.imem_req, imem_if.imem_addr}), 32'({1'b1, 8'hFF}));
    check("jmp_pc", 32'(pc), 32'h0FF);
    check("jmp_instret", 32'(instret), 6);
    tick(1);
    check("wrap_pc", 32'(pc), 0);
    wait_cfg = 5;
    tick(3);
    check("wrap_fetch", 32'({imem_if.imem_req, imem_if.imem_addr}), 32'({1'b1, 8'h00}));
    check("wrap_instret", 32'(instret), 7);

    // Reset during an outstanding fetch
    res = 1'b0;
    exp_q.delete();
    pending = 1'b0;
    #1;
    check("midrst_outputs", out_vec(), 0);
    check("midrst_pc", 32'(pc), 0);
    check("midrst_instret", 32'(instret), 0);
    tick(2);
    res = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("midrst_idle_%0d", i), out_vec(), 0);
    end

    // Three wait states on fetch at pc 0
    wait_cfg = 3;
    exp_q.push_back('{addr: 8'h00, word: 16'h1250});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws_req_addr_%0d", i),
            32'({imem_if.imem_req, imem_if.imem_addr, dec_en}), 32'({1'b1, 8'h00, 1'b0}));
      check($sformatf("ws_inst_hold_%0d", i), 32'(inst), 0);
      tick(1);
    end
    check("ws_decode", 32'({imem_if.imem_req, dec_en, inst}), 32'({1'b0, 1'b1, 16'h1250}));
    check("ws_pc", 32'(pc), 1);
    tick(2);
    check("ws_wb", 32'(wb_en), 1);
    tick(1);
    check("ws_instret", 32'(instret), 1);
    res = 1'b0;
    tick(2);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
